// File: rtl/instr_block_memory.sv
// rtl/instr_block_memory.sv - instruction block memory, READ/BUSYWAIT block-fetch responder
//
// Serves 16-byte instruction blocks after a fixed multi-cycle latency and
// accepts byte writes through a separate program port.
//
// Optional feature macro: IMEM_FETCH_COUNT_EN (adds FETCH_COUNT output).
//
// Parameters:
//   READ_CYCLES       cycles from READ sampled to data valid (1..255)
//   BLOCK_ADDR_WIDTH  block address width; 2^BLOCK_ADDR_WIDTH blocks of 16 bytes
//
// Ports:
//   CLK          clock, all state updates on posedge
//   RESET        synchronous active-low reset
//   READ         fetch request level, held until BUSYWAIT seen low
//   ADDRESS      block address, latched at request acceptance
//   READDATA     fetched block (registered, byte k at bits 8k+7:8k)
//   BUSYWAIT     stall to initiator (combinational)
//   PROG_WRITE   single-cycle byte write strobe
//   PROG_ADDR    byte address of program write
//   PROG_DATA    byte to write
//   FETCH_COUNT  completed fetch count (only with IMEM_FETCH_COUNT_EN)

module instr_block_memory #(
    parameter int READ_CYCLES      = 5,
    parameter int BLOCK_ADDR_WIDTH = 6
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        READ,
    input  logic [BLOCK_ADDR_WIDTH-1:0] ADDRESS,
    output logic [127:0]                READDATA,
    output logic                        BUSYWAIT,
    input  logic                        PROG_WRITE,
    input  logic [BLOCK_ADDR_WIDTH+3:0] PROG_ADDR,
    input  logic [7:0]                  PROG_DATA
`ifdef IMEM_FETCH_COUNT_EN
    ,
    output logic [15:0]                 FETCH_COUNT
`endif
);

    localparam int NUM_BYTES = 16 * (2 ** BLOCK_ADDR_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [7:0]                  count;
    logic [7:0]                  count_next;
    logic                        accept;
    logic                        load_en;
    logic [BLOCK_ADDR_WIDTH-1:0] addr_q;
    logic [127:0]                block_rd;
    logic [7:0]                  mem [NUM_BYTES];

    // Storage is deliberately not reset; program writes are gated by reset.
    always_ff @(posedge CLK) begin
        if (RESET && PROG_WRITE) begin
            mem[PROG_ADDR] <= PROG_DATA;
        end
    end

    // Block is read at the completing edge, so a write on that same edge
    // lands after the sample and the old byte is returned.
    always_comb begin
        block_rd = '0;
        for (int k = 0; k < 16; k++) begin
            block_rd[8*k +: 8] = mem[{addr_q, 4'(k)}];
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        load_en    = 1'b0;
        case (state)
            IDLE: begin
                if (READ) begin
                    accept     = 1'b1;
                    count_next = 8'(READ_CYCLES - 1);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (count != 8'd0) begin
                    count_next = count - 8'd1;
                end else begin
                    load_en    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= IDLE;
            count    <= 8'd0;
            addr_q   <= '0;
            READDATA <= 128'h0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) begin
                addr_q <= ADDRESS;
            end
            if (load_en) begin
                READDATA <= block_rd;
            end
        end
    end

    // The IDLE term lets the initiator see a stall in the same cycle it raises READ.
    assign BUSYWAIT = RESET && (((state == IDLE) && READ) || (state == BUSY));

`ifdef IMEM_FETCH_COUNT_EN
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            FETCH_COUNT <= 16'h0000;
        end else if (load_en) begin
            FETCH_COUNT <= FETCH_COUNT + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_instr_block_memory.sv
// tb/tb_instr_block_memory.sv - directed self-checking bench for instr_block_memory

module tb_instr_block_memory;

    logic         CLK;
    logic         RESET;
    logic         READ;
    logic [5:0]   ADDRESS;
    logic [127:0] READDATA;
    logic         BUSYWAIT;
    logic         PROG_WRITE;
    logic [9:0]   PROG_ADDR;
    logic [7:0]   PROG_DATA;
`ifdef IMEM_FETCH_COUNT_EN
    logic [15:0]  FETCH_COUNT;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] BLK1     = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] BLK2     = 128'h8F8E8D8C8B8A89888786858483828180;
    localparam logic [127:0] BLK1_NEW = 128'h550E0D0C0B0A090807060504030201AA;

    instr_block_memory #(
        .READ_CYCLES      (5),
        .BLOCK_ADDR_WIDTH (6)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .READ       (READ),
        .ADDRESS    (ADDRESS),
        .READDATA   (READDATA),
        .BUSYWAIT   (BUSYWAIT),
        .PROG_WRITE (PROG_WRITE),
        .PROG_ADDR  (PROG_ADDR),
        .PROG_DATA  (PROG_DATA)
`ifdef IMEM_FETCH_COUNT_EN
        ,
        .FETCH_COUNT(FETCH_COUNT)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic prog_byte(input logic [9:0] a, input logic [7:0] d);
        PROG_WRITE = 1'b1;
        PROG_ADDR  = a;
        PROG_DATA  = d;
        tick();
        PROG_WRITE = 1'b0;
    endtask

    initial begin
        RESET      = 1'b0;
        READ       = 1'b1;
        ADDRESS    = 6'd0;
        PROG_WRITE = 1'b0;
        PROG_ADDR  = 10'd0;
        PROG_DATA  = 8'd0;

        // Reset held two edges with READ high
        tick();
        tick();
        check_eq("rst_busywait", {127'd0, BUSYWAIT}, 128'd0);
        check_eq("rst_readdata", READDATA, 128'h0);

        READ  = 1'b0;
        RESET = 1'b1;
        tick();
        check_eq("idle_no_read_bw", {127'd0, BUSYWAIT}, 128'd0);

        for (int i = 0; i < 16; i++) prog_byte(10'h010 + 10'(i), 8'(i));
        for (int i = 0; i < 16; i++) prog_byte(10'h020 + 10'(i), 8'h80 + 8'(i));

        // Fetch block 1; ADDRESS moves to block 2 mid-fetch and must be ignored
        READ    = 1'b1;
        ADDRESS = 6'd1;
        #1;
        check_eq("idle_read_bw", {127'd0, BUSYWAIT}, 128'd1);
        tick();                                  // E0
        for (int c = 1; c <= 4; c++) begin
            if (c == 1) ADDRESS = 6'd2;
            tick();
            check_eq($sformatf("busy_bw_%0d", c), {127'd0, BUSYWAIT}, 128'd1);
        end
        tick();                                  // E0+5 -> DONE
        check_eq("done_bw", {127'd0, BUSYWAIT}, 128'd0);
        check_eq("fetch_blk1", READDATA, BLK1);

        // READ kept high through DONE: new request for block 2
        tick();                                  // E0+6 IDLE with READ
        check_eq("b2b_idle_bw", {127'd0, BUSYWAIT}, 128'd1);
        check_eq("b2b_hold_data", READDATA, BLK1);
        for (int c = 7; c <= 11; c++) begin
            tick();
            check_eq($sformatf("b2b_busy_bw_%0d", c), {127'd0, BUSYWAIT}, 128'd1);
        end
        check_eq("b2b_hold_data2", READDATA, BLK1);
        tick();                                  // E0+12
        check_eq("b2b_done_bw", {127'd0, BUSYWAIT}, 128'd0);
        check_eq("fetch_blk2", READDATA, BLK2);
        READ = 1'b0;
        tick();
        check_eq("after_done_bw", {127'd0, BUSYWAIT}, 128'd0);
`ifdef IMEM_FETCH_COUNT_EN
        check_eq("count_two", {112'd0, FETCH_COUNT}, 128'd2);
`endif

        // Reset mid-fetch: abandoned, no DONE, data cleared
        READ    = 1'b1;
        ADDRESS = 6'd1;
        tick();                                  // E0
        READ = 1'b0;
        tick();
        tick();                                  // E0+2
        RESET = 1'b0;
        tick();                                  // E0+3
        check_eq("midrst_bw", {127'd0, BUSYWAIT}, 128'd0);
        check_eq("midrst_data", READDATA, 128'h0);
        RESET = 1'b1;
        for (int c = 4; c <= 7; c++) begin
            tick();
            check_eq($sformatf("midrst_no_done_%0d", c), READDATA, 128'h0);
        end
`ifdef IMEM_FETCH_COUNT_EN
        check_eq("midrst_count", {112'd0, FETCH_COUNT}, 128'd0);
`endif

        // READ pulsed for one cycle: fetch still completes
        READ    = 1'b1;
        ADDRESS = 6'd1;
        tick();                                  // E0
        READ = 1'b0;
        for (int c = 1; c <= 4; c++) tick();
        check_eq("drop_busy_bw", {127'd0, BUSYWAIT}, 128'd1);
        // Program write to byte 0 on the completing edge: old byte returned
        prog_byte(10'h010, 8'hAA);               // E0+5
        check_eq("collide_done_bw", {127'd0, BUSYWAIT}, 128'd0);
        check_eq("collide_byte0", {120'd0, READDATA[7:0]}, 128'h00);
        check_eq("collide_block", READDATA, BLK1);
        tick();
        check_eq("collide_back_idle", {127'd0, BUSYWAIT}, 128'd0);

        // Refetch; a write early in BUSY is visible at completion
        READ = 1'b1;
        tick();                                  // E0
        READ = 1'b0;
        tick();
        prog_byte(10'h01F, 8'h55);               // E0+2
        tick();
        tick();
        tick();                                  // E0+5
        check_eq("refetch_byte0", {120'd0, READDATA[7:0]}, 128'hAA);
        check_eq("refetch_block", READDATA, BLK1_NEW);
`ifdef IMEM_FETCH_COUNT_EN
        check_eq("count_after_refetch", {112'd0, FETCH_COUNT}, 128'd2);
`endif

        // Program writes ignored while reset low
        RESET = 1'b0;
        prog_byte(10'h010, 8'h11);
        RESET   = 1'b1;
        READ    = 1'b1;
        ADDRESS = 6'd1;
        tick();
        READ = 1'b0;
        for (int c = 1; c <= 5; c++) tick();
        check_eq("rst_write_ignored", READDATA, BLK1_NEW);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_block_memory.md
Name: instr_block_memory

Overview:
- Instruction-side backing memory: the responder end of the READ/BUSYWAIT block-fetch handshake that a cache uses toward memory.
- Serves 16-byte (128-bit) instruction blocks to a future instruction cache, addressed by 6-bit block address.
- Multi-cycle read latency, modelled with a counter/FSM.
- Separate byte-wide program port so benches load code through the port instead of poking arrays.

Parameters:
READ_CYCLES, 5, cycles from READ sampled to data valid; legal range 1..255
BLOCK_ADDR_WIDTH, 6, block address width; depth = 2^BLOCK_ADDR_WIDTH blocks of 16 bytes (1024 bytes at default)

Ports:
CLK  input  1  clock, all state updates on posedge
RESET  input  1  synchronous, active-low reset (sampled on posedge CLK)
READ  input  1  fetch request, level; held high by initiator until BUSYWAIT observed low
ADDRESS  input  BLOCK_ADDR_WIDTH  block address; sampled only at request acceptance
READDATA  output  128  fetched block, registered
BUSYWAIT  output  1  stall to initiator
PROG_WRITE  input  1  single-cycle byte write strobe
PROG_ADDR  input  BLOCK_ADDR_WIDTH+4  byte address
PROG_DATA  input  8  byte to write

Behaviour:
- Storage: byte array, 16*2^BLOCK_ADDR_WIDTH entries. Block b, byte k (0..15) maps to READDATA[8k+7:8k] (little-endian, byte address b*16+k). Storage contents are not cleared by reset.
- FSM states: IDLE, BUSY, DONE.
- Reset (RESET==0 at posedge): state=IDLE, counter=0, READDATA=128'h0. BUSYWAIT forced 0 while RESET low. An in-flight fetch is abandoned with no data update.
- BUSYWAIT is combinational: 1 when (state==IDLE && READ) or state==BUSY; 0 in DONE and in IDLE without READ.
- IDLE: on posedge with READ=1:
  - latch ADDRESS;
  - counter = READ_CYCLES-1;
  - go to BUSY.
  READ=0 stays IDLE.
- BUSY, counter!=0: counter decrements.
- BUSY, counter==0: load READDATA from the latched block; go to DONE.
- Latency: READ sampled at edge E0; READDATA valid and BUSYWAIT low after edge E0+READ_CYCLES.
- DONE: BUSYWAIT=0 for exactly one cycle; unconditional go to IDLE at next posedge. The initiator drops READ at the edge where it sees BUSYWAIT low. If READ is still high in the following IDLE cycle, it is a new request and is accepted at that next posedge.
- ADDRESS changes during BUSY are ignored, because the address is latched.
- READ dropped during BUSY: the fetch still completes, READDATA updates, and DONE is still visited.
- READDATA holds its value until the next completed fetch or reset.
- Program port:
  - PROG_WRITE=1 at posedge writes PROG_DATA to PROG_ADDR in any state.
  - The write is not blocked by an active fetch and does not stall it.
  - A write on the same edge as the completing fetch load of that block is not visible in that fetch; the old byte is returned.
  - A write earlier in BUSY is visible, because data is read at completion.
- Program writes are ignored while RESET is low.

Optional Feature:
- Macro IMEM_FETCH_COUNT_EN.
- Defined: adds output FETCH_COUNT [15:0].
  - Increments by 1 on each BUSY->DONE transition.
  - Wraps 16'hFFFF -> 16'h0000.
  - Cleared to 0 by reset.
  - Abandoned fetches are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold RESET=0 two edges with READ=1 -> BUSYWAIT=0, READDATA=128'h0; release, READ=1 at edge E0 -> BUSYWAIT=1 until E0+5.
- Load/fetch: program bytes 0x00..0x0F at byte addresses 0x010..0x01F, READ=1, ADDRESS=6'd1 -> after 5 cycles READDATA=128'h0F0E0D0C0B0A09080706050403020100, BUSYWAIT=0 for one cycle.
- Address stability: start fetch of block 1, change ADDRESS to 6'd2 at E0+2 -> block 1 data returned.
- Back-to-back: keep READ=1 through DONE with ADDRESS=6'd2 -> second request accepted one cycle after DONE, data after another 5 cycles.
- Reset mid-operation: RESET=0 at E0+3 -> IDLE, READDATA=0, no DONE cycle; with IMEM_FETCH_COUNT_EN, FETCH_COUNT stays 0.
- Write collision: PROG_WRITE byte addr 0x010 = 8'hAA at the completing edge -> READDATA[7:0]=8'h00; refetch -> 8'hAA.
